// File: rtl/hall_pulse_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : hall_pulse_gen_if
// Description : Command handshake bundle (speed, direction, valid/ready)
//               between the GPIO source and the hall pulse generator.
// Revision    : 1.0 - initial release
// ============================================================================
interface hall_pulse_gen_if;
    logic [15:0] rpm_cmd;
    logic        dir;
    logic        cmd_valid;
    logic        cmd_ready;

    modport master (output rpm_cmd, output dir, output cmd_valid, input  cmd_ready);
    modport slave  (input  rpm_cmd, input  dir, input  cmd_valid, output cmd_ready);
endinterface
`default_nettype wire

// File: rtl/hall_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : hall_pulse_gen
// Description : Hall-sensor emulator turning an RPM/direction command into
//               SA/SB quadrature pulses with a serial divider for the period.
// Revision    : 1.0 - initial release
// ============================================================================
module hall_pulse_gen #(
    parameter int unsigned CLK_FREQ_HZ    = 100_000_000,
    parameter int unsigned PULSES_PER_REV = 1
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    hall_pulse_gen_if.slave     cmd,
    output logic                sa_output,
    output logic                sb_output,
    output logic                running,
    output logic [15:0]         rev_count
);

    // Clocks per quarter step at 1 RPM: f*60 / (4*PPR) = f*15/PPR
    localparam logic [63:0] NUM_WIDE  = (64'(CLK_FREQ_HZ) * 64'd15) / 64'(PULSES_PER_REV);
    localparam logic [31:0] NUMERATOR = NUM_WIDE[31:0];

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_cmd_ready;
    logic [15:0] r_rpm;
    logic        r_dir;
    logic [31:0] r_num;
    logic [15:0] r_rem;
    logic [31:0] r_quo;
    logic [4:0]  r_div_cnt;
    logic [31:0] r_q;
    logic [31:0] r_qcnt;
    logic        r_sa;
    logic        r_sb;
    logic        r_running;
    logic [15:0] r_rev_count;

    logic        w_accept;
    logic        w_rpm_zero;
    logic [16:0] w_rem_shift;
    logic        w_ge;
    logic [15:0] w_rem_next;
    logic [31:0] w_quo_next;
    logic        w_sa_next;
    logic        w_sb_next;

    assign w_accept   = cmd.cmd_valid && r_cmd_ready;
    assign w_rpm_zero = (cmd.rpm_cmd == 16'd0);

    // One restoring-division step: bring in the next numerator bit
    assign w_rem_shift = {r_rem, r_num[31]};
    assign w_ge        = (w_rem_shift >= {1'b0, r_rpm});
    assign w_rem_next  = w_ge ? 16'(w_rem_shift - {1'b0, r_rpm}) : w_rem_shift[15:0];
    assign w_quo_next  = {r_quo[30:0], w_ge};

    // Gray-code step from the current levels, so direction flips never skip
    assign w_sa_next = r_dir ? ~r_sb : r_sb;
    assign w_sb_next = r_dir ? r_sa  : ~r_sa;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
            r_rpm       <= 16'd0;
            r_dir       <= 1'b0;
            r_num       <= 32'd0;
            r_rem       <= 16'd0;
            r_quo       <= 32'd0;
            r_div_cnt   <= 5'd0;
            r_q         <= 32'd0;
            r_qcnt      <= 32'd0;
            r_sa        <= 1'b0;
            r_sb        <= 1'b0;
            r_running   <= 1'b0;
            r_rev_count <= 16'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_accept && !w_rpm_zero) begin
                        r_rpm       <= cmd.rpm_cmd;
                        r_dir       <= cmd.dir;
                        r_num       <= NUMERATOR;
                        r_rem       <= 16'd0;
                        r_quo       <= 32'd0;
                        r_div_cnt   <= 5'd0;
                        r_cmd_ready <= 1'b0;
                        r_state     <= DIVIDE;
                    end
                end

                DIVIDE: begin
                    r_num     <= {r_num[30:0], 1'b0};
                    r_rem     <= w_rem_next;
                    r_quo     <= w_quo_next;
                    r_div_cnt <= r_div_cnt + 5'd1;
                    if (r_div_cnt == 5'd31) begin
                        r_q         <= (w_quo_next == 32'd0) ? 32'd1 : w_quo_next;
                        r_qcnt      <= 32'd0;
                        r_running   <= 1'b1;
                        r_cmd_ready <= 1'b1;
                        r_state     <= RUN;
                    end
                end

                RUN: begin
                    if (w_accept) begin
                        r_running <= 1'b0;
                        if (w_rpm_zero) begin
                            r_state <= IDLE;
                        end else begin
                            r_rpm       <= cmd.rpm_cmd;
                            r_dir       <= cmd.dir;
                            r_num       <= NUMERATOR;
                            r_rem       <= 16'd0;
                            r_quo       <= 32'd0;
                            r_div_cnt   <= 5'd0;
                            r_cmd_ready <= 1'b0;
                            r_state     <= DIVIDE;
                        end
                    end else if (r_qcnt == r_q - 32'd1) begin
                        r_qcnt <= 32'd0;
                        r_sa   <= w_sa_next;
                        r_sb   <= w_sb_next;
                        if (!r_sa && w_sa_next) begin
                            r_rev_count <= r_rev_count + 16'd1;
                        end
                    end else begin
                        r_qcnt <= r_qcnt + 32'd1;
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_running   <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cmd.cmd_ready = r_cmd_ready;
    assign sa_output     = r_sa;
    assign sb_output     = r_sb;
    assign running       = r_running;
    assign rev_count     = r_rev_count;

endmodule
`default_nettype wire

// File: tb/tb_hall_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_hall_pulse_gen
// Description : Directed bench for hall_pulse_gen with a queue of expected
//               quadrature steps checked by an output-change monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hall_pulse_gen;

    localparam int unsigned CLK_FREQ_HZ    = 1000;
    localparam int unsigned PULSES_PER_REV = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sa_output;
    logic        sb_output;
    logic        running;
    logic [15:0] rev_count;

    hall_pulse_gen_if cmd_if ();

    hall_pulse_gen #(
        .CLK_FREQ_HZ    (CLK_FREQ_HZ),
        .PULSES_PER_REV (PULSES_PER_REV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (cmd_if),
        .sa_output (sa_output),
        .sb_output (sb_output),
        .running   (running),
        .rev_count (rev_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         t;
        logic [1:0] st;
    } step_t;

    step_t      exp_q[$];
    logic [1:0] m_st = 2'b00;
    logic [1:0] prev = 2'b00;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Queue n expected steps starting at first_edge, spaced q edges apart
    task automatic push_steps(input int n, input int q, input int first_edge, input logic d);
        step_t s;
        for (int i = 0; i < n; i++) begin
            if (d) m_st = {~m_st[0], m_st[1]};
            else   m_st = {m_st[0], ~m_st[1]};
            s.t  = first_edge + i * q;
            s.st = m_st;
            exp_q.push_back(s);
        end
    endtask

    task automatic send_cmd(input logic [15:0] rpm, input logic d, output int e0);
        @(negedge clk);
        check("ready_before_cmd", 32'(cmd_if.cmd_ready), 32'd1);
        cmd_if.rpm_cmd   = rpm;
        cmd_if.dir       = d;
        cmd_if.cmd_valid = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_empty(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("steps_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk or negedge rst_n) begin
        step_t e;
        if (!rst_n) begin
            prev = 2'b00;
        end else if ({sa_output, sb_output} !== prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_change", 32'({sa_output, sb_output}), 32'(prev));
            end else begin
                e = exp_q.pop_front();
                check("step_time",  32'(cyc), 32'(e.t));
                check("step_state", 32'({sa_output, sb_output}), 32'(e.st));
            end
            check("one_bit_change", 32'($countones({sa_output, sb_output} ^ prev)), 32'd1);
            prev = {sa_output, sb_output};
        end
    end

    initial begin
        int e0;
        int zeros;

        cmd_if.rpm_cmd   = 16'd0;
        cmd_if.dir       = 1'b0;
        cmd_if.cmd_valid = 1'b0;

        #1;
        check("reset_outputs", 32'({sa_output, sb_output}), 32'd0);
        check("reset_running", 32'(running), 32'd0);
        check("reset_rev",     32'(rev_count), 32'd0);
        check("reset_ready",   32'(cmd_if.cmd_ready), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(cmd_if.cmd_ready), 32'd1);

        // Forward 60 RPM: Q = 15000/60 = 250, four full cycles
        send_cmd(16'd60, 1'b1, e0);
        check("running_in_divide", 32'(running), 32'd0);
        push_steps(16, 250, e0 + 32 + 250, 1'b1);
        wait_empty(5000);
        check("rev_after_fwd", 32'(rev_count), 32'd4);
        check("running_in_run", 32'(running), 32'd1);

        // Reverse 120 RPM: Q = 125, then reversal mid-run
        send_cmd(16'd120, 1'b0, e0);
        push_steps(3, 125, e0 + 32 + 125, 1'b0);
        wait_empty(1000);
        check("rev_after_reverse", 32'(rev_count), 32'd5);
        send_cmd(16'd120, 1'b1, e0);
        push_steps(4, 125, e0 + 32 + 125, 1'b1);
        wait_empty(1000);
        check("rev_after_flip", 32'(rev_count), 32'd6);

        // Stop: outputs stay frozen
        send_cmd(16'd0, 1'b1, e0);
        check("stop_running", 32'(running), 32'd0);
        check("stop_ready",   32'(cmd_if.cmd_ready), 32'd1);
        repeat (600) @(negedge clk);
        check("stop_hold", 32'({sa_output, sb_output}), 32'(m_st));

        // Clamp Q=1 and handshake ignored during DIVIDE
        send_cmd(16'd65535, 1'b1, e0);
        push_steps(8, 1, e0 + 33, 1'b1);
        zeros = 0;
        for (int i = 0; i < 32; i++) begin
            if (!cmd_if.cmd_ready) zeros++;
            if (i == 4) begin
                cmd_if.rpm_cmd   = 16'd5;
                cmd_if.dir       = 1'b0;
                cmd_if.cmd_valid = 1'b1;
            end else if (i == 5) begin
                cmd_if.cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("divide_ready_low", 32'(zeros), 32'd32);
        check("ready_after_divide", 32'(cmd_if.cmd_ready), 32'd1);
        while (cyc != e0 + 39) @(negedge clk);
        send_cmd(16'd0, 1'b1, e0);
        wait_empty(10);
        check("rev_after_clamp", 32'(rev_count), 32'd8);

        // Async reset mid-RUN
        send_cmd(16'd60, 1'b1, e0);
        push_steps(5, 250, e0 + 32 + 250, 1'b1);
        wait_empty(2000);
        check("rev_before_reset", 32'(rev_count), 32'd9);
        #1 rst_n = 1'b0;
        #1;
        check("async_outputs", 32'({sa_output, sb_output}), 32'd0);
        check("async_rev",     32'(rev_count), 32'd0);
        check("async_running", 32'(running), 32'd0);
        #1 rst_n = 1'b1;
        m_st = 2'b00;
        @(negedge clk);
        send_cmd(16'd60, 1'b1, e0);
        push_steps(4, 250, e0 + 32 + 250, 1'b1);
        wait_empty(1500);
        check("rev_after_restart", 32'(rev_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
